bias_vector_replay: RTL and testbench
=====================================

// Module: bias_vector_replay
// PURPOSE
//  Buffers one per-column bias vector (DIM2 words) from an AXI-Stream load port and replays it
//  row by row, DIM1 times, as a DIM1xDIM2 stream aligned with the matmul output order.
//  Feeds the bias input of requant ahead of gelu_top in the FFN path. Re-arms after each full replay.
// PARAMETERS
//  X_W           32    input word width (signed)
//  Y_W           32    output word width (signed); X_W>Y_W keeps low Y_W bits, X_W<Y_W sign-extends
//  MATRIXSIZE_W  16    width of DIM1/DIM2 and internal counters
//  MEM_DEPTH     768   vector RAM depth; DIM2 must be <= MEM_DEPTH
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             asynchronous active-low reset
//  in_tdata     in   X_W           bias word
//  in_tlast     in   1             end of vector marker (checked, not used for counting)
//  in_tvalid    in   1             load valid
//  in_tready    out  1             load ready
//  out_tdata    out  Y_W           replayed bias word
//  out_tlast    out  1             high on word DIM1*DIM2-1 only
//  out_tvalid   out  1             replay valid
//  out_tready   in   1             replay ready
//  DIM1         in   MATRIXSIZE_W  rows to replay
//  DIM2         in   MATRIXSIZE_W  vector length
//  len_err      out  1             sticky: in_tlast disagreed with word count DIM2-1
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=LOAD, counters 0, in_tready=0, out_tvalid=0,
//   out_tlast=0, out_tdata=0, len_err=0. in_tready rises first cycle after reset release.
//  LOAD: DIM1/DIM2 sampled into regs every cycle until the first beat is accepted, then frozen
//   until end of PLAY. If sampled DIM1==0 or DIM2==0: in_tready=0, wait. Else in_tready=1;
//   each in_tvalid&&in_tready writes RAM[wr_idx], wr_idx++. Beat DIM2-1 -> PLAY next cycle,
//   in_tready drops that same next cycle. len_err sets if in_tlast=1 on beat <DIM2-1 or 0 on beat DIM2-1.
//  PLAY: col cycles 0..DIM2-1, row 0..DIM1-1; RAM read is 1-cycle synchronous; 2-entry output
//   skid FIFO; read issued only if FIFO has a free slot counting in-flight reads.
//   Sustains 1 word/cycle with out_tready held high; out_tvalid never drops mid-stream
//   except under back-pressure. First out_tvalid 2 cycles after last load beat.
//   out_tdata/out_tlast held stable while out_tvalid&&!out_tready (AXIS rule).
//  Exit: on the handshake of the out_tlast word -> LOAD next cycle, wr_idx=0, dims re-sampled.
//   No overlap: next vector cannot load during PLAY (single buffer).
//  DIM1=1,DIM2=1: one load beat, one out beat with out_tlast=1.
//  Reset mid-PLAY/LOAD: stream aborted, FIFO flushed, RAM contents don't care, back to LOAD.
//  in_tvalid during PLAY ignored (in_tready=0); out_tready during LOAD ignored (out_tvalid=0).
// STRUCTURE
//  Package (dims or shared pkg): typedef enum logic {BVR_LOAD, BVR_PLAY} bvr_state_t.
//  Sub-module: sdp_ram #(.W(Y_W),.DEPTH(MEM_DEPTH)) - 1 write port, 1 registered read port, no reset.
//  Top holds FSM, wr/col/row counters, in-flight tracking, 2-entry skid FIFO, width conversion.
// TESTING
//  1 Load DIM2=4 {1,-2,3,-4}, DIM1=3, out_tready=1 -> 12 words 1,-2,3,-4 x3, tlast only on 12th,
//    no valid gaps after the first.
//  2 Same, out_tready random 50% -> identical sequence, data stable under stall, no drops/dups.
//  3 X_W=32,Y_W=8, load 0x0000_0181 -> out 0x81 (-127); Y_W=32,X_W=16, 0x8000 -> 0xFFFF_8000.
//  4 in_tlast on beat 1 of DIM2=4 -> len_err=1 and stays 1; loading still completes on beat 3.
//  5 Two back-to-back vectors, DIM2=2 then 3 (dims changed during first PLAY) -> second replay
//    uses DIM2=3; in_tready low for all of first PLAY.
//  6 rst_n low mid-PLAY at word 5 -> outputs 0 same cycle; after release, fresh load/replay correct.

Source files
------------

// File: rtl/bias_vector_replay_pkg.sv
// Shared types for the bias vector replay block.
// FSM state encoding plus the skid FIFO occupancy helper.
package bias_vector_replay_pkg;

    typedef enum logic {
        BVR_LOAD,
        BVR_PLAY
    } bvr_state_t;

    localparam int BVR_FIFO_DEPTH = 2;

    // Slots claimed once this cycle settles: stored + landing - leaving.
    function automatic logic [1:0] bvr_occupancy(
        input logic [1:0] cnt,
        input logic       in_flight,
        input logic       pop
    );
        return cnt + {1'b0, in_flight} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/bias_vector_replay_if.sv
// AXI-Stream load and replay channels of the bias vector replay block.
// slave is the block side, master is the producer/consumer side.
interface bias_vector_replay_if #(
    parameter int X_W = 32,
    parameter int Y_W = 32
);
    logic [X_W-1:0] in_tdata;
    logic           in_tlast;
    logic           in_tvalid;
    logic           in_tready;
    logic [Y_W-1:0] out_tdata;
    logic           out_tlast;
    logic           out_tvalid;
    logic           out_tready;

    modport slave (
        input  in_tdata, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tlast, out_tvalid
    );

    modport master (
        output in_tdata, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tlast, out_tvalid
    );
endinterface

// File: rtl/bias_vector_replay_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on storage or read register.
module sdp_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 768,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/bias_vector_replay.sv
// Bias vector replay: loads one DIM2-word vector, then streams it DIM1 times.
// Single buffer; the next vector loads only after the last replayed word leaves.
module bias_vector_replay
    import bias_vector_replay_pkg::*;
#(
    parameter int X_W          = 32,
    parameter int Y_W          = 32,
    parameter int MATRIXSIZE_W = 16,
    parameter int MEM_DEPTH    = 768
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bias_vector_replay_if.slave     axis,
    input  logic [MATRIXSIZE_W-1:0] DIM1,
    input  logic [MATRIXSIZE_W-1:0] DIM2,
    output logic                    len_err
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef logic [MATRIXSIZE_W-1:0] cnt_t;

    bvr_state_t state;
    cnt_t       dim1_r;
    cnt_t       dim2_r;
    cnt_t       wr_idx;
    cnt_t       col;
    cnt_t       row;
    logic       in_rdy;
    logic       issue_done;
    logic       rd_vld;
    logic       rd_last;

    logic [Y_W-1:0] fifo_data [BVR_FIFO_DEPTH];
    logic           fifo_last [BVR_FIFO_DEPTH];
    logic           rd_ptr;
    logic           wr_ptr;
    logic [1:0]     fifo_cnt;

    logic [Y_W-1:0] wr_word;
    logic [Y_W-1:0] ram_rd;

    logic in_fire;
    logic last_beat;
    logic dims_ok;
    logic sample;
    logic out_vld;
    logic pop;
    logic col_last;
    logic row_last;
    logic issue;
    logic play_done;

    generate
        if (X_W >= Y_W) begin : g_trunc
            assign wr_word = axis.in_tdata[Y_W-1:0];
            if (X_W > Y_W) begin : g_hi
                logic unused_hi;
                assign unused_hi = ^axis.in_tdata[X_W-1:Y_W];
            end
        end else begin : g_sext
            assign wr_word = {{(Y_W-X_W){axis.in_tdata[X_W-1]}},
                              axis.in_tdata};
        end
    endgenerate

    assign in_fire   = axis.in_tvalid && in_rdy;
    assign last_beat = (wr_idx == dim2_r - 1'b1);
    assign dims_ok   = (DIM1 != '0) && (DIM2 != '0);
    assign sample    = (state == BVR_LOAD) && (wr_idx == '0) && !in_fire;
    assign out_vld   = (fifo_cnt != 2'd0);
    assign pop       = out_vld && axis.out_tready;
    assign col_last  = (col == dim2_r - 1'b1);
    assign row_last  = (row == dim1_r - 1'b1);
    assign play_done = pop && fifo_last[rd_ptr];

    // A read is only launched when the FIFO can absorb it on landing.
    assign issue = (state == BVR_PLAY) && !issue_done &&
                   (bvr_occupancy(fifo_cnt, rd_vld, pop) < 2'd2);

    assign axis.in_tready  = in_rdy;
    assign axis.out_tvalid = out_vld;
    assign axis.out_tdata  = fifo_data[rd_ptr];
    assign axis.out_tlast  = fifo_last[rd_ptr];

    sdp_ram #(
        .W     (Y_W),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (in_fire),
        .wa  (wr_idx[AW-1:0]),
        .wd  (wr_word),
        .re  (issue),
        .ra  (col[AW-1:0]),
        .rd  (ram_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BVR_LOAD;
            dim1_r     <= '0;
            dim2_r     <= '0;
            wr_idx     <= '0;
            col        <= '0;
            row        <= '0;
            in_rdy     <= 1'b0;
            issue_done <= 1'b0;
            len_err    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_last <= issue && col_last && row_last;
            unique case (state)
                BVR_LOAD: begin
                    if (sample) begin
                        dim1_r <= DIM1;
                        dim2_r <= DIM2;
                        in_rdy <= dims_ok;
                    end
                    if (in_fire) begin
                        if (axis.in_tlast != last_beat) len_err <= 1'b1;
                        if (last_beat) begin
                            state  <= BVR_PLAY;
                            in_rdy <= 1'b0;
                            wr_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                BVR_PLAY: begin
                    if (issue) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (col_last && row_last) issue_done <= 1'b1;
                    end
                    // Re-arm on the final handshake; dims taken fresh here.
                    if (play_done) begin
                        state      <= BVR_LOAD;
                        col        <= '0;
                        row        <= '0;
                        issue_done <= 1'b0;
                        dim1_r     <= DIM1;
                        dim2_r     <= DIM2;
                        in_rdy     <= dims_ok;
                    end
                end
                default: state <= BVR_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BVR_FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (rd_vld) begin
                fifo_data[wr_ptr] <= ram_rd;
                fifo_last[wr_ptr] <= rd_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_bias_vector_replay.sv
// Scoreboard bench for bias_vector_replay: random vectors and back-pressure,
// expected replay order built from the vector and dims, checked by a monitor.
module tb_bias_vector_replay;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dim1;
    logic [15:0] dim2;
    logic        len_err;
    logic        len_err_n;
    logic        len_err_w;

    always #5 clk = ~clk;

    bias_vector_replay_if #(.X_W(32), .Y_W(32)) ifc ();
    bias_vector_replay_if #(.X_W(32), .Y_W(8))  ifn ();
    bias_vector_replay_if #(.X_W(16), .Y_W(32)) ifw ();

    bias_vector_replay #(
        .X_W(32), .Y_W(32), .MATRIXSIZE_W(16), .MEM_DEPTH(768)
    ) dut (
        .clk(clk), .rst_n(rst_n), .axis(ifc.slave),
        .DIM1(dim1), .DIM2(dim2), .len_err(len_err)
    );

    bias_vector_replay #(
        .X_W(32), .Y_W(8), .MATRIXSIZE_W(16), .MEM_DEPTH(16)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .axis(ifn.slave),
        .DIM1(16'd1), .DIM2(16'd1), .len_err(len_err_n)
    );

    bias_vector_replay #(
        .X_W(16), .Y_W(32), .MATRIXSIZE_W(16), .MEM_DEPTH(16)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .axis(ifw.slave),
        .DIM1(16'd1), .DIM2(16'd1), .len_err(len_err_w)
    );

    exp_t        q[$];
    logic [31:0] vbuf[$];
    int          checks = 0;
    int          passes = 0;
    int          popped = 0;
    bit          model_err = 0;
    bit          rdy_mode = 0;
    bit          gap_chk = 0;

    task automatic chk(input string nm, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok === 1'b1) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic fill_rand(input int n);
        vbuf.delete();
        for (int i = 0; i < n; i++) vbuf.push_back($urandom);
    endtask

    // Sends vbuf as one vector; tlast is inverted on beat bad (if >= 0).
    task automatic load_vec(input int d1, input int d2, input int bad);
        logic got;
        dim1 = d1[15:0];
        dim2 = d2[15:0];
        @(posedge clk);
        #1;
        for (int c = 0; c < d2; c++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            ifc.in_tdata  = vbuf[c];
            ifc.in_tlast  = (c == d2 - 1) ^ (c == bad);
            ifc.in_tvalid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 3000 && !got; t++) begin
                @(negedge clk);
                got = ifc.in_tready;
            end
            if (!got) begin
                chk("in_tready_timeout", 1'b0, 64'd0, 64'd1);
                ifc.in_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            ifc.in_tvalid = 1'b0;
        end
        if (bad >= 0 && bad < d2) model_err = 1;
        for (int r = 0; r < d1; r++)
            for (int c = 0; c < d2; c++)
                q.push_back('{d: vbuf[c], l: (r == d1 - 1) && (c == d2 - 1)});
        chk("len_err", len_err == model_err, 64'(len_err), 64'(model_err));
    endtask

    task automatic drain();
        for (int t = 0; t < 4000 && q.size() > 0; t++) @(negedge clk);
        chk("drain", q.size() == 0, 64'(q.size()), 64'd0);
    endtask

    initial begin
        ifc.out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic        pv, pr, pl, phs;
        logic [31:0] pd;
        exp_t        e;
        pv = 0; pr = 0; pl = 0; pd = 0; phs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv  = 0;
                phs = 0;
            end else begin
                if (pv && !pr)
                    chk("stall_hold",
                        ifc.out_tvalid && ifc.out_tdata == pd && ifc.out_tlast == pl,
                        {ifc.out_tvalid, ifc.out_tlast, ifc.out_tdata},
                        {1'b1, pl, pd});
                if (gap_chk && phs && q.size() > 0)
                    chk("valid_gap", ifc.out_tvalid, 64'(ifc.out_tvalid), 64'd1);
                if (q.size() > 0)
                    chk("in_tready_play", !ifc.in_tready,
                        64'(ifc.in_tready), 64'd0);
                phs = ifc.out_tvalid && ifc.out_tready;
                if (phs) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 1'b0, 64'(ifc.out_tdata), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("out_word",
                            ifc.out_tdata == e.d && ifc.out_tlast == e.l,
                            {ifc.out_tlast, ifc.out_tdata}, {e.l, e.d});
                        popped++;
                    end
                end
                pv = ifc.out_tvalid;
                pr = ifc.out_tready;
                pd = ifc.out_tdata;
                pl = ifc.out_tlast;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        ifc.in_tvalid = 0; ifc.in_tdata = 0; ifc.in_tlast = 0;
        ifn.in_tvalid = 0; ifn.in_tdata = 0; ifn.in_tlast = 0;
        ifw.in_tvalid = 0; ifw.in_tdata = 0; ifw.in_tlast = 0;
        ifn.out_tready = 1; ifw.out_tready = 1;
        dim1 = 16'd3;
        dim2 = 16'd4;

        repeat (3) @(negedge clk);
        chk("rst_out_tvalid", ifc.out_tvalid == 0, 64'(ifc.out_tvalid), 64'd0);
        chk("rst_out_tlast", ifc.out_tlast == 0, 64'(ifc.out_tlast), 64'd0);
        chk("rst_out_tdata", ifc.out_tdata == 0, 64'(ifc.out_tdata), 64'd0);
        chk("rst_in_tready", ifc.in_tready == 0, 64'(ifc.in_tready), 64'd0);
        chk("rst_len_err", len_err == 0, 64'(len_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_tready_rise", ifc.in_tready == 1, 64'(ifc.in_tready), 64'd1);

        ifn.in_tdata = 32'h0000_0181; ifn.in_tlast = 1; ifn.in_tvalid = 1;
        ifw.in_tdata = 16'h8000;      ifw.in_tlast = 1; ifw.in_tvalid = 1;
        @(posedge clk);
        #1;
        ifn.in_tvalid = 0;
        ifw.in_tvalid = 0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = ifn.out_tvalid && ifw.out_tvalid;
        end
        chk("width_valid", got, 64'(got), 64'd1);
        chk("trunc_y8", ifn.out_tdata == 8'h81 && ifn.out_tlast,
            {ifn.out_tlast, ifn.out_tdata}, {1'b1, 8'h81});
        chk("sext_x16", ifw.out_tdata == 32'hFFFF_8000 && ifw.out_tlast,
            {ifw.out_tlast, ifw.out_tdata}, {1'b1, 32'hFFFF_8000});

        vbuf = '{32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC};
        gap_chk = 1;
        load_vec(3, 4, -1);
        drain();
        gap_chk = 0;

        rdy_mode = 1;
        vbuf = '{32'h1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFC};
        load_vec(3, 4, -1);
        drain();

        fill_rand(4);
        load_vec(2, 4, 1);
        drain();

        fill_rand(2);
        load_vec(3, 2, -1);
        fill_rand(3);
        load_vec(2, 3, -1);
        drain();

        @(negedge clk);
        dim1 = 16'd0;
        repeat (3) @(negedge clk);
        chk("zero_dim_idle", ifc.in_tready == 0, 64'(ifc.in_tready), 64'd0);

        rdy_mode = 0;
        popped = 0;
        fill_rand(4);
        load_vec(3, 4, -1);
        for (int t = 0; t < 200 && popped < 5; t++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tvalid", ifc.out_tvalid == 0, 64'(ifc.out_tvalid), 64'd0);
        chk("abort_tdata", ifc.out_tdata == 0, 64'(ifc.out_tdata), 64'd0);
        chk("abort_tlast", ifc.out_tlast == 0, 64'(ifc.out_tlast), 64'd0);
        chk("abort_len_err", len_err == 0, 64'(len_err), 64'd0);
        q.delete();
        model_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_rand(3);
        load_vec(2, 3, -1);
        drain();

        for (int i = 0; i < 6; i++) begin
            int d1, d2;
            rdy_mode = 1'($urandom_range(0, 1));
            d1 = (i == 0) ? 1 : $urandom_range(1, 4);
            d2 = (i == 0) ? 1 : $urandom_range(1, 6);
            fill_rand(d2);
            load_vec(d1, d2, -1);
            drain();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
